// File: rtl/ram_arb_pkg.sv
// Shared constants and helpers for the RAM port-B arbiter.
package ram_arb_pkg;

  localparam int unsigned REQ_CPU = 0;
  localparam int unsigned REQ_DMA = 1;
  localparam int unsigned REQ_VID = 2;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_ADDR_WIDTH = 16;

  // Widest requester vector the helpers accept.
  localparam int unsigned MAX_REQ = 8;

  // Index of the set bit in a one-hot vector; zero when no bit is set.
  function automatic logic [2:0] onehot2idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_portb_arbiter_if.sv
// Requester fabric and RAM port-B signals seen by the arbiter.
interface ram_portb_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            we;
  logic [NUM_REQ*ADDR_WIDTH-1:0] addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            rvalid;
  logic [DATA_WIDTH-1:0]         rdata;

  logic                          ram_we;
  logic [ADDR_WIDTH-1:0]         ram_addr;
  logic [DATA_WIDTH-1:0]         ram_din;
  logic [DATA_WIDTH-1:0]         ram_dout;

  // Requester fabric side.
  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  // Arbiter side.
  modport slave (
    input  req, we, addr, wdata, ram_dout,
    output gnt, rvalid, rdata, ram_we, ram_addr, ram_din
  );

  // Block RAM port B.
  modport ram (
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );

endinterface

// File: rtl/ram_portb_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last_idx wins.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_idx,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;

  // Rotate so that bit 0 is the requester just after last_idx, then take the first set bit.
  always_comb begin
    dbl  = {req, req};
    rot  = N'(dbl >> (32'(last_idx) + 32'd1));
    pick = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (rot[k] && (pick == '0)) begin
        pick = N'(1) << ((32'(last_idx) + 32'd1 + k) % N);
      end
    end
  end

  assign idx = IW'(onehot2idx(MAX_REQ'(pick)));

endmodule

// File: rtl/ram_portb_arbiter.sv
// Port-B arbiter for the 64KB block RAM: round-robin with optional CPU priority,
// bounded bursts, registered RAM command and a two-stage read-tag pipeline.
module ram_portb_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned BURST_MAX  = 4,
  parameter bit          PRIO0      = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  ram_portb_arbiter_if.slave bus
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(BURST_MAX) + 1;
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX - 1);

  logic [IW-1:0]         last_idx;
  logic [CW-1:0]         burst_cnt;
  logic                  prev_any;
  logic [NUM_REQ-1:0]    rr_gnt;
  logic [IW-1:0]         rr_idx;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [IW-1:0]         win_idx;
  logic [NUM_REQ-1:0]    others;
  logic                  keep;
  logic                  any_gnt;
  logic [NUM_REQ-1:0]    rd_tag1;
  logic [NUM_REQ-1:0]    rd_tag2;

  logic [ADDR_WIDTH-1:0] addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = bus.wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req      (bus.req),
    .last_idx (last_idx),
    .pick     (rr_gnt),
    .idx      (rr_idx)
  );

  // Winner selection: CPU override, burst continuation, otherwise round-robin.
  always_comb begin
    gnt_c   = '0;
    win_idx = '0;
    others  = bus.req & ~(NUM_REQ'(1) << last_idx);
    keep    = bus.req[last_idx] && (burst_cnt < BURST_LIM) && (others == '0);
    if (PRIO0 && bus.req[REQ_CPU]) begin
      gnt_c   = NUM_REQ'(1) << REQ_CPU;
      win_idx = IW'(REQ_CPU);
    end else if (keep) begin
      gnt_c   = NUM_REQ'(1) << last_idx;
      win_idx = last_idx;
    end else begin
      gnt_c   = rr_gnt;
      win_idx = rr_idx;
    end
  end

  assign any_gnt    = |gnt_c;
  assign bus.gnt    = gnt_c;
  assign bus.rvalid = rd_tag2;
  assign bus.rdata  = bus.ram_dout;

  // Last-winner pointer and saturating run length of consecutive grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_idx  <= IW'(NUM_REQ - 1);
      burst_cnt <= '0;
      prev_any  <= 1'b0;
    end else begin
      prev_any <= any_gnt;
      if (any_gnt) begin
        last_idx <= win_idx;
        if (prev_any && (win_idx == last_idx)) begin
          burst_cnt <= (burst_cnt == BURST_LIM) ? burst_cnt : burst_cnt + CW'(1);
        end else begin
          burst_cnt <= '0;
        end
      end else begin
        burst_cnt <= '0;
      end
    end
  end

  // Register the winning command toward RAM port B; address/data hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
    end else begin
      bus.ram_we <= any_gnt & bus.we[win_idx];
      if (any_gnt) begin
        bus.ram_addr <= addr_a[win_idx];
        bus.ram_din  <= wdata_a[win_idx];
      end
    end
  end

  // Track which requester owns each read in flight, aligned with RAM dout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_tag1 <= '0;
      rd_tag2 <= '0;
    end else begin
      rd_tag1 <= gnt_c & ~bus.we;
      rd_tag2 <= rd_tag1;
    end
  end

endmodule

// File: tb/tb_ram_portb_arbiter.sv
// Directed bench for ram_portb_arbiter: cycle table plus priority and reset sequences.
module tb_ram_portb_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  ram_portb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus   ();
  ram_portb_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_p ();

  ram_portb_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .BURST_MAX(4), .PRIO0(1'b0)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  ram_portb_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .BURST_MAX(1), .PRIO0(1'b1)
  ) u_dut_p (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_p)
  );

  // Port-B RAM models: dout only updates on read cycles.
  logic [DW-1:0] mem   [65536];
  logic [DW-1:0] mem_p [65536];

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    else            bus.ram_dout <= mem[bus.ram_addr];
  end

  always @(posedge clk) begin
    if (bus_p.ram_we) mem_p[bus_p.ram_addr] <= bus_p.ram_din;
    else              bus_p.ram_dout <= mem_p[bus_p.ram_addr];
  end

  typedef struct {
    logic [NR-1:0] req;
    logic [NR-1:0] we;
    logic [AW-1:0] a0, a1, a2;
    logic [DW-1:0] wd2;
    logic [NR-1:0] gnt;
    logic [NR-1:0] rv;
    logic [DW-1:0] rdata;
    logic          ram_we;
    logic          chk_addr;
    logic [AW-1:0] ram_addr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [NR-1:0] req, input logic [NR-1:0] we,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input logic [AW-1:0] a2, input logic [DW-1:0] wd2,
                              input logic [NR-1:0] gnt, input logic [NR-1:0] rv,
                              input logic [DW-1:0] rdata, input logic ram_we,
                              input logic chk_addr, input logic [AW-1:0] ram_addr);
    vec_t v;
    v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.wd2 = wd2;
    v.gnt = gnt; v.rv = rv; v.rdata = rdata; v.ram_we = ram_we;
    v.chk_addr = chk_addr; v.ram_addr = ram_addr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [NR-1:0] req, input logic [NR-1:0] we,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic [AW-1:0] a2, input logic [DW-1:0] wd2);
    bus.req   = req;
    bus.we    = we;
    bus.addr  = {a2, a1, a0};
    bus.wdata = {wd2, 8'h00, 8'h00};
  endtask

  logic [NR-1:0] p_req [7];
  logic [NR-1:0] p_gnt [7];
  logic [NR-1:0] p_rv  [7];
  logic [DW-1:0] p_rd  [7];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]   = 8'h00;
      mem_p[i] = 8'h00;
    end
    mem[16'h1234] = 8'hA5;
    mem[16'h0010] = 8'h11; mem[16'h0011] = 8'h22; mem[16'h0012] = 8'h33;
    mem_p[16'h0010] = 8'h11; mem_p[16'h0011] = 8'h22; mem_p[16'h0012] = 8'h33;

    drive('0, '0, '0, '0, '0, '0);
    bus_p.req = '0; bus_p.we = '0;
    bus_p.addr = {16'h0012, 16'h0011, 16'h0010}; bus_p.wdata = '0;

    // test 1: single read
    tbl.push_back(mk(3'b001, 3'b000, 16'h1234, 16'h0, 16'h0, 8'h0, 3'b001, 3'b000, 8'h00, 1'b0, 1'b1, 16'h0000));
    tbl.push_back(mk(3'b000, 3'b000, 16'h1234, 16'h0, 16'h0, 8'h0, 3'b000, 3'b000, 8'h00, 1'b0, 1'b1, 16'h1234));
    tbl.push_back(mk(3'b000, 3'b000, 16'h1234, 16'h0, 16'h0, 8'h0, 3'b000, 3'b001, 8'hA5, 1'b0, 1'b1, 16'h1234));
    tbl.push_back(mk(3'b000, 3'b000, 16'h0,    16'h0, 16'h0, 8'h0, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 16'h0000));
    // test 2: all request, rotation
    tbl.push_back(mk(3'b111, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b010, 3'b000, 8'h00, 1'b0, 1'b0, 16'h0000));
    tbl.push_back(mk(3'b111, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b100, 3'b000, 8'h00, 1'b0, 1'b1, 16'h0011));
    tbl.push_back(mk(3'b111, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b001, 3'b010, 8'h22, 1'b0, 1'b1, 16'h0012));
    tbl.push_back(mk(3'b111, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b010, 3'b100, 8'h33, 1'b0, 1'b1, 16'h0010));
    tbl.push_back(mk(3'b111, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b100, 3'b001, 8'h11, 1'b0, 1'b1, 16'h0011));
    tbl.push_back(mk(3'b000, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b000, 3'b010, 8'h22, 1'b0, 1'b1, 16'h0012));
    tbl.push_back(mk(3'b000, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b000, 3'b100, 8'h33, 1'b0, 1'b1, 16'h0012));
    // test 3: lone burst from requester 1, then requester 2 joins
    tbl.push_back(mk(3'b010, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b010, 3'b000, 8'h00, 1'b0, 1'b1, 16'h0012));
    tbl.push_back(mk(3'b010, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b010, 3'b000, 8'h00, 1'b0, 1'b1, 16'h0011));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(3'b010, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b010, 3'b010, 8'h22, 1'b0, 1'b1, 16'h0011));
    tbl.push_back(mk(3'b110, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b100, 3'b010, 8'h22, 1'b0, 1'b1, 16'h0011));
    tbl.push_back(mk(3'b010, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b010, 3'b010, 8'h22, 1'b0, 1'b1, 16'h0012));
    tbl.push_back(mk(3'b000, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b000, 3'b100, 8'h33, 1'b0, 1'b1, 16'h0011));
    tbl.push_back(mk(3'b000, 3'b000, 16'h10, 16'h11, 16'h12, 8'h0, 3'b000, 3'b010, 8'h22, 1'b0, 1'b1, 16'h0011));
    // test 5: write then read-after-write
    tbl.push_back(mk(3'b100, 3'b100, 16'h0, 16'h00FF, 16'h00FF, 8'h5A, 3'b100, 3'b000, 8'h00, 1'b0, 1'b1, 16'h0011));
    tbl.push_back(mk(3'b010, 3'b000, 16'h0, 16'h00FF, 16'h00FF, 8'h00, 3'b010, 3'b000, 8'h00, 1'b1, 1'b1, 16'h00FF));
    tbl.push_back(mk(3'b000, 3'b000, 16'h0, 16'h0,    16'h0,    8'h00, 3'b000, 3'b000, 8'h00, 1'b0, 1'b1, 16'h00FF));
    tbl.push_back(mk(3'b000, 3'b000, 16'h0, 16'h0,    16'h0,    8'h00, 3'b000, 3'b010, 8'h5A, 1'b0, 1'b1, 16'h00FF));
    tbl.push_back(mk(3'b000, 3'b000, 16'h0, 16'h0,    16'h0,    8'h00, 3'b000, 3'b000, 8'h00, 1'b0, 1'b0, 16'h0000));

    // reset values
    repeat (2) @(negedge clk);
    check("rst gnt",      32'(bus.gnt),      32'h0);
    check("rst rvalid",   32'(bus.rvalid),   32'h0);
    check("rst ram_we",   32'(bus.ram_we),   32'h0);
    check("rst ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rst ram_din",  32'(bus.ram_din),  32'h0);
    check("rst p rvalid", 32'(bus_p.rvalid), 32'h0);
    rst_n = 1'b1;

    // cycle table on the round-robin instance
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].a2, tbl[i].wd2);
      #1;
      check($sformatf("row%0d gnt", i),    32'(bus.gnt),    32'(tbl[i].gnt));
      check($sformatf("row%0d rvalid", i), 32'(bus.rvalid), 32'(tbl[i].rv));
      check($sformatf("row%0d ram_we", i), 32'(bus.ram_we), 32'(tbl[i].ram_we));
      if (tbl[i].rv != '0)
        check($sformatf("row%0d rdata", i), 32'(bus.rdata), 32'(tbl[i].rdata));
      if (tbl[i].chk_addr)
        check($sformatf("row%0d ram_addr", i), 32'(bus.ram_addr), 32'(tbl[i].ram_addr));
    end

    // test 4: CPU priority pulse on the PRIO0 instance
    p_req = '{3'b110, 3'b110, 3'b111, 3'b110, 3'b110, 3'b000, 3'b000};
    p_gnt = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    p_rv  = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    p_rd  = '{8'h00,  8'h00,  8'h22,  8'h33,  8'h11,  8'h22,  8'h33};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus_p.req = p_req[i];
      #1;
      check($sformatf("prio%0d gnt", i),    32'(bus_p.gnt),    32'(p_gnt[i]));
      check($sformatf("prio%0d rvalid", i), 32'(bus_p.rvalid), 32'(p_rv[i]));
      if (p_rv[i] != '0)
        check($sformatf("prio%0d rdata", i), 32'(bus_p.rdata), 32'(p_rd[i]));
    end

    // test 6a: reset one cycle after a read grant drops the read
    @(posedge clk); #1;
    drive(3'b001, 3'b000, 16'h1234, 16'h0, 16'h0, 8'h0);
    #1; check("rstA gnt", 32'(bus.gnt), 32'h1);
    @(posedge clk); #1;
    drive('0, '0, '0, '0, '0, '0);
    #1; check("rstA ram_addr pre", 32'(bus.ram_addr), 32'h1234);
    rst_n = 1'b0;
    #1;
    check("rstA rvalid",   32'(bus.rvalid),   32'h0);
    check("rstA ram_addr", 32'(bus.ram_addr), 32'h0);
    check("rstA ram_we",   32'(bus.ram_we),   32'h0);
    @(negedge clk); rst_n = 1'b1;
    // pointer reset: requester 0 beats requester 2 on the first cycle
    @(posedge clk); #1;
    drive(3'b101, 3'b101, 16'h0300, 16'h0, 16'h0301, 8'h77);
    #1;
    check("rstA post gnt",    32'(bus.gnt),    32'h1);
    check("rstA post rvalid", 32'(bus.rvalid), 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive('0, '0, '0, '0, '0, '0);
      #1; check($sformatf("rstA rvalid%0d", i), 32'(bus.rvalid), 32'h0);
    end

    // test 6b: async reset drops a pending RAM write
    @(posedge clk); #1;
    drive(3'b100, 3'b100, 16'h0, 16'h0, 16'h0200, 8'hC3);
    #1; check("rstB gnt", 32'(bus.gnt), 32'h4);
    @(posedge clk); #1;
    drive('0, '0, '0, '0, '0, '0);
    #1;
    check("rstB ram_we pre",  32'(bus.ram_we),  32'h1);
    check("rstB ram_din pre", 32'(bus.ram_din), 32'hC3);
    rst_n = 1'b0;
    #1;
    check("rstB ram_we",   32'(bus.ram_we),   32'h0);
    check("rstB ram_din",  32'(bus.ram_din),  32'h0);
    check("rstB ram_addr", 32'(bus.ram_addr), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
